// File: rtl/decodificador_teclado.sv
// Keypad front-end for operacional.
//
// Scans a 4x4 active-high matrix keypad, debounces press and release, and shift-accumulates
// decoded keys into a 20-nibble buffer (nibble 0 = newest key, unused nibbles = 0xF).
// '*' (0xA) and '#' (0xB) terminate an entry: the buffer reads all 1s the cycle after their pulse.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   teclado_en     keypad enable; 0 blocks the keypad and clears the buffer
//   col_matrix     matrix columns, active-high (external pull-downs)
//   lin_matrix     matrix row drive, one-hot active-high (0 while disabled)
//   digitos_value  20-nibble key buffer
//   digitos_valid  one-cycle pulse; digitos_value already holds the new key in that cycle
//
// Optional feature (macro TECLADO_TIMEOUT_EN): a partial entry left idle in SCAN for
// TIMEOUT_S * UM_SEGUNDO cycles is discarded without a pulse.

module decodificador_teclado #(
  parameter int unsigned UM_SEGUNDO      = 1000,
  parameter int unsigned SCAN_CYCLES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_S       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        teclado_en,
  input  logic [3:0]  col_matrix,
  output logic [3:0]  lin_matrix,
  output logic [79:0] digitos_value,
  output logic        digitos_valid
);

  localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] KeyStar = 4'hA;
  localparam logic [3:0] KeyHash = 4'hB;

  if (SCAN_CYCLES == 0 || DEBOUNCE_CYCLES == 0 || TIMEOUT_S * UM_SEGUNDO == 0) begin : g_bad_cfg
    $error("decodificador_teclado: cycle counts must be non-zero");
  end

  typedef enum logic [2:0] {
    StDisabled,
    StScan,
    StDebounce,
    StEmit,
    StWaitRelease
  } state_e;

  state_e           state_q;
  logic [1:0]       row_q;
  logic [ScanW-1:0] scan_cnt_q;
  logic [DebW-1:0]  deb_cnt_q;   // press debounce, then reused for release debounce
  logic [3:0]       col_q;
  logic [3:0]       code_q;

`ifdef TECLADO_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = TIMEOUT_S * UM_SEGUNDO;
  localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 1);
  logic [ToW-1:0] to_cnt_q;
`endif

  // Column decode: exactly one of cols 0..2 is a key; col 3 (letters) or a chord is no key.
  logic       col_ok;
  logic [1:0] col_idx;
  logic [3:0] key_code;

  always_comb begin
    col_ok  = 1'b0;
    col_idx = 2'd0;
    case (col_matrix)
      4'b0001: begin col_ok = 1'b1; col_idx = 2'd0; end
      4'b0010: begin col_ok = 1'b1; col_idx = 2'd1; end
      4'b0100: begin col_ok = 1'b1; col_idx = 2'd2; end
      default: begin col_ok = 1'b0; col_idx = 2'd0; end
    endcase

    key_code = 4'h0;
    if (row_q == 2'd3) begin
      case (col_idx)
        2'd0:    key_code = KeyStar;
        2'd1:    key_code = 4'h0;
        default: key_code = KeyHash;
      endcase
    end else begin
      // Rows 0..2 hold digits 1..9 in reading order.
      key_code = {2'b00, row_q} * 4'd3 + {2'b00, col_idx} + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StScan;
      row_q         <= 2'd0;
      scan_cnt_q    <= '0;
      deb_cnt_q     <= '0;
      col_q         <= 4'b0000;
      code_q        <= 4'h0;
      lin_matrix    <= 4'b0001;
      digitos_value <= '1;
      digitos_valid <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else if (!teclado_en) begin
      // Disable wins over every state: a pending key is dropped without a pulse.
      state_q       <= StDisabled;
      row_q         <= 2'd0;
      scan_cnt_q    <= '0;
      deb_cnt_q     <= '0;
      lin_matrix    <= 4'b0000;
      digitos_value <= '1;
      digitos_valid <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      digitos_valid <= 1'b0;
      case (state_q)
        StDisabled: begin
          state_q    <= StScan;
          row_q      <= 2'd0;
          scan_cnt_q <= '0;
          lin_matrix <= 4'b0001;
        end

        StScan: begin
          if (scan_cnt_q == ScanLast) begin
            scan_cnt_q <= '0;
            if (col_ok) begin
              // Hold this row and lock onto the column seen.
              state_q   <= StDebounce;
              col_q     <= col_matrix;
              code_q    <= key_code;
              deb_cnt_q <= '0;
            end else begin
              row_q      <= row_q + 2'd1;
              lin_matrix <= {lin_matrix[2:0], lin_matrix[3]};
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end

        StDebounce: begin
          if (col_matrix == col_q) begin
            if (deb_cnt_q == DebLast) begin
              // Buffer and pulse are registered together so the pulse cycle shows the key.
              state_q       <= StEmit;
              digitos_value <= {digitos_value[75:0], code_q};
              digitos_valid <= 1'b1;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            state_q    <= StScan;
            row_q      <= row_q + 2'd1;
            lin_matrix <= {lin_matrix[2:0], lin_matrix[3]};
          end
        end

        StEmit: begin
          state_q   <= StWaitRelease;
          deb_cnt_q <= '0;
          if (code_q == KeyStar || code_q == KeyHash) begin
            digitos_value <= '1;
          end
        end

        StWaitRelease: begin
          if (col_matrix == 4'b0000) begin
            if (deb_cnt_q == DebLast) begin
              state_q    <= StScan;
              row_q      <= row_q + 2'd1;
              lin_matrix <= {lin_matrix[2:0], lin_matrix[3]};
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            deb_cnt_q <= '0;
          end
        end

        default: begin
          state_q    <= StScan;
          row_q      <= 2'd0;
          scan_cnt_q <= '0;
          lin_matrix <= 4'b0001;
        end
      endcase

`ifdef TECLADO_TIMEOUT_EN
      // Only idle scanning with a partial entry ages it; an empty buffer stops the counter.
      if (state_q == StEmit) begin
        to_cnt_q <= '0;
      end else if (state_q == StScan && digitos_value != '1) begin
        if (to_cnt_q == ToLast) begin
          digitos_value <= '1;
          to_cnt_q      <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

endmodule
